// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 fetch path.
//   iu_t     : integer-unit word (addresses, stack cells)
//   u8_t     : one bytecode byte
//   ROM_AW   : byte-address width of the eForth image ROM (8K x 8)
//   PF_DEPTH : default prefetch queue depth in bytes
package ej32_pkg;
  localparam int IU_W     = 32;
  localparam int ROM_AW   = 13;
  localparam int PF_DEPTH = 4;

  typedef logic [IU_W-1:0] iu_t;
  typedef logic [7:0]      u8_t;
endpackage

// File: rtl/ej32_bfifo.sv
// Parameterised byte FIFO for the bytecode prefetch queue.
// Ports:
//   clk, rst : clock, synchronous active-high reset (also zeroes storage)
//   clr_i    : synchronous clear of pointers and count; wins over push/pop
//   push_i   : write din_i at the tail (ignored when full and not popping)
//   din_i    : byte to write
//   pop_i    : advance the head (ignored when empty)
//   dout_o   : head entry, read combinationally from the array
//   cnt_o    : number of stored bytes, 0..DEPTH
module ej32_bfifo
  import ej32_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  u8_t                      din_i,
  input  logic                     pop_i,
  output u8_t                      dout_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  u8_t           mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop, wr_en;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    // A full FIFO may still accept a byte when the head leaves the same cycle.
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      wr_en = do_push;
      if (do_pop)  head_d = head_q + PW'(1);
      if (do_push) tail_d = tail_q + PW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (wr_en) mem_q[tail_q] <= din_i;
    end
  end

  assign dout_o = mem_q[head_q];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/ej32_prefetch.sv
// Bytecode prefetch queue between the eForth image ROM (registered read,
// one cycle latency) and the eJ32 decoder.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   flush    : redirect the fetch stream to flush_a this cycle
//   flush_a  : new fetch address
//   rom_a    : ROM byte address (ROM uses the low ROM_AW bits)
//   rom_d    : ROM byte for the address presented last cycle
//   ib_d     : head byte
//   ib_pc    : address of the head byte
//   ib_v     : head byte valid
//   ib_rdy   : decoder ready
// Handshake: the decoder takes the head byte in every cycle where
// ib_v && ib_rdy is high and flush is low; ib_d/ib_pc hold while ib_v is
// high and ib_rdy is low. A flush discards everything, including a pop
// offered in the same cycle.
module ej32_prefetch
  import ej32_pkg::*;
#(
  parameter int            DEPTH = PF_DEPTH,
  parameter int            AW    = IU_W,
  parameter logic [AW-1:0] RST_A = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [AW-1:0] flush_a,
  output logic [AW-1:0] rom_a,
  input  u8_t           rom_d,
  output u8_t           ib_d,
  output logic [AW-1:0] ib_pc,
  output logic          ib_v,
  input  logic          ib_rdy
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] fa_q, fa_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic          issue, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_cnt;

  always_comb begin
    rom_a      = flush ? flush_a : fa_q;
    // Reserve a slot for the read already in flight; a pop in this cycle is
    // not credited, so a push can never land in a full FIFO.
    issue      = flush || ((int'(fifo_cnt) + int'(inflight_q)) < DEPTH);
    inflight_d = issue;
    fa_d       = issue ? (rom_a + AW'(1)) : fa_q;
    // A response in flight during a flush belongs to the old stream.
    fifo_push  = inflight_q && !flush;
    fifo_pop   = ib_v && ib_rdy && !flush;
    pc_d       = pc_q;
    if (flush)         pc_d = flush_a;
    else if (fifo_pop) pc_d = pc_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fa_q       <= RST_A;
      pc_q       <= RST_A;
      inflight_q <= 1'b0;
    end else begin
      fa_q       <= fa_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
    end
  end

  ej32_bfifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (flush),
    .push_i (fifo_push),
    .din_i  (rom_d),
    .pop_i  (fifo_pop),
    .dout_o (ib_d),
    .cnt_o  (fifo_cnt)
  );

  assign ib_v  = (fifo_cnt != '0);
  assign ib_pc = pc_q;
endmodule

// File: tb/tb_ej32_prefetch.sv
module tb_ej32_prefetch;
  import ej32_pkg::*;

  localparam int            DEPTH = 4;
  localparam int            AW    = 32;
  localparam logic [AW-1:0] RST_A = '0;
  localparam int            ROM_N = 1 << ROM_AW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, ib_v, ib_rdy;
  logic [AW-1:0] flush_a, rom_a, ib_pc;
  logic [7:0]    rom_d, ib_d;

  ej32_prefetch #(.DEPTH(DEPTH), .AW(AW), .RST_A(RST_A)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_a(flush_a), .rom_a(rom_a),
    .rom_d(rom_d), .ib_d(ib_d), .ib_pc(ib_pc), .ib_v(ib_v), .ib_rdy(ib_rdy)
  );

  // ROM model: registered read, address wraps through the low ROM_AW bits
  logic [7:0] rom [ROM_N];
  always @(posedge clk) rom_d <= rom[rom_a[ROM_AW-1:0]];

  // scoreboard: expected {pc, byte} stream from the last redirect
  logic [AW+7:0] exp_q[$];
  logic [AW-1:0] gen_pc;
  int n_chk = 0, n_pass = 0, n_pop = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back({gen_pc, rom[gen_pc[ROM_AW-1:0]]});
      gen_pc = gen_pc + 1;
    end
  endtask

  task automatic start_stream(input logic [AW-1:0] a);
    exp_q.delete();
    gen_pc = a;
    refill();
  endtask

  function automatic logic [7:0] rom_at(input logic [AW-1:0] a);
    return rom[a[ROM_AW-1:0]];
  endfunction

  // monitor: every accepted byte must be the next one of the current stream
  always @(negedge clk) begin
    if (!rst && ib_v && ib_rdy && !flush) begin
      logic [AW+7:0] e;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got pc %0h byte %0h with nothing expected", ib_pc, ib_d);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 64'(ib_pc), 64'(e[AW+7:8]));
        check("sb_byte", 64'(ib_d), 64'(e[7:0]));
        refill();
      end
    end
    if (!rst && dut.fifo_push && !dut.fifo_pop && dut.fifo_cnt == DEPTH) begin
      n_chk++;
      $display("FAIL overflow: push into full FIFO, cnt %0d", dut.fifo_cnt);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic rdy);
    cyc();
    rst = 1'b1; flush = 1'b0; ib_rdy = rdy;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    start_stream(RST_A);
  endtask

  logic [7:0] first4 [4];

  initial begin
    first4[0] = 8'h10; first4[1] = 8'h20; first4[2] = 8'h30; first4[3] = 8'h40;
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) rom[i] = first4[i];
    rst = 1'b1; flush = 1'b0; flush_a = '0; ib_rdy = 1'b1;
    cyc(); cyc();
    neg();
    check("rst_ib_v", 64'(ib_v), 64'd0);
    check("rst_ib_pc", 64'(ib_pc), 64'(RST_A));
    check("rst_ib_d", 64'(ib_d), 64'd0);
    check("rst_rom_a", 64'(rom_a), 64'(RST_A));

    // reset release, streaming at full rate
    cyc();
    rst = 1'b0;
    start_stream(RST_A);
    neg();
    check("rel_c0_v", 64'(ib_v), 64'd0);
    check("rel_c0_rom_a", 64'(rom_a), 64'(RST_A));
    cyc(); neg();
    check("rel_c1_v", 64'(ib_v), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); neg();
      check("rel_v", 64'(ib_v), 64'd1);
      check("rel_pc", 64'(ib_pc), 64'(k));
      check("rel_d", 64'(ib_d), 64'(first4[k]));
    end

    // backpressure from reset release
    do_reset(1'b0);
    repeat (10) cyc();
    neg();
    check("bp_rom_a", 64'(rom_a), 64'd4);
    check("bp_cnt", 64'(dut.fifo_cnt), 64'(DEPTH));
    check("bp_v", 64'(ib_v), 64'd1);
    cyc();
    ib_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      neg();
      check("bp_resume_v", 64'(ib_v), 64'd1);
      check("bp_resume_pc", 64'(ib_pc), 64'(k));
      cyc();
    end

    // flush with 3 bytes buffered and a read in flight
    do_reset(1'b0);
    repeat (4) cyc();
    flush = 1'b1; flush_a = 32'h100; ib_rdy = 1'b1;
    start_stream(32'h100);
    neg();
    check("fl_pre_cnt", 64'(dut.fifo_cnt), 64'd3);
    check("fl_rom_a", 64'(rom_a), 64'h100);
    cyc();
    flush = 1'b0;
    neg();
    check("fl_f1_v", 64'(ib_v), 64'd0);
    cyc(); neg();
    check("fl_f2_v", 64'(ib_v), 64'd1);
    check("fl_f2_pc", 64'(ib_pc), 64'h100);
    check("fl_f2_d", 64'(ib_d), 64'(rom_at(32'h100)));
    repeat (3) cyc();

    // flush coincident with a pop, then back-to-back flushes
    flush = 1'b1; flush_a = 32'h200;
    start_stream(32'h200);
    neg();
    check("bb_pre_v", 64'(ib_v), 64'd1);
    cyc();
    flush_a = 32'h300;
    start_stream(32'h300);
    neg();
    check("bb_f1_pc", 64'(ib_pc), 64'h200);
    check("bb_f1_v", 64'(ib_v), 64'd0);
    cyc();
    flush = 1'b0;
    neg();
    check("bb_f2_pc", 64'(ib_pc), 64'h300);
    check("bb_f2_v", 64'(ib_v), 64'd0);
    cyc(); neg();
    check("bb_f3_v", 64'(ib_v), 64'd1);
    check("bb_f3_pc", 64'(ib_pc), 64'h300);
    check("bb_f3_d", 64'(ib_d), 64'(rom_at(32'h300)));
    repeat (4) cyc();

    // ROM wrap at 8K
    flush = 1'b1; flush_a = 32'h1FFE;
    start_stream(32'h1FFE);
    cyc();
    flush = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      neg();
      check("wrap_pc", 64'(ib_pc), 64'(32'h1FFE + k));
      check("wrap_d", 64'(ib_d), 64'(rom[(32'h1FFE + k) % ROM_N]));
      cyc();
    end

    // mid-stream reset together with a flush
    rst = 1'b1; flush = 1'b1; flush_a = 32'h555;
    exp_q.delete();
    cyc();
    rst = 1'b0; flush = 1'b0;
    start_stream(RST_A);
    neg();
    check("mrst_c0_v", 64'(ib_v), 64'd0);
    check("mrst_c0_pc", 64'(ib_pc), 64'(RST_A));
    cyc(); neg();
    check("mrst_c1_v", 64'(ib_v), 64'd0);
    cyc(); neg();
    check("mrst_c2_v", 64'(ib_v), 64'd1);
    check("mrst_c2_pc", 64'(ib_pc), 64'(RST_A));
    check("mrst_c2_d", 64'(ib_d), 64'(rom_at(RST_A)));

    // random backpressure and redirects
    n_pop = 0;
    for (int i = 0; i < 800; i++) begin
      cyc();
      ib_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        flush   = 1'b1;
        flush_a = $urandom;
        start_stream(flush_a);
      end else begin
        flush = 1'b0;
      end
    end
    cyc();
    flush = 1'b0;
    repeat (3) cyc();
    check("rand_progress", 64'(n_pop > 300), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ej32_prefetch.md
Name: ej32_prefetch

Overview:
- Bytecode prefetch queue placed directly downstream of the eForth image ROM (8K x 8 EBR with a registered read, 1-cycle latency).
- Drives the ROM byte address sequentially and captures the returned bytes into a small FIFO.
- Presents bytes in order, each tagged with its address, to the eJ32 decoder over a valid/ready handshake.
- Supports a same-cycle redirect (flush) for branches, calls and returns.

Parameters:
- DEPTH, 4, FIFO entries in bytes; power of two, minimum 2.
- AW, 32, address width of the IU type.
- RST_A, 0, fetch address after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  redirect the fetch stream to flush_a this cycle
- flush_a  in  AW  new fetch address
- rom_a  out  AW  byte address to the ROM; the ROM uses bits [12:0]
- rom_d  in  8  ROM data for the address presented on the previous cycle
- ib_d  out  8  head byte
- ib_pc  out  AW  address of the head byte
- ib_v  out  1  head byte valid
- ib_rdy  in  1  decoder consumes the head byte when ib_v && ib_rdy

Behaviour:
- Reset values: FIFO empty, cnt=0, ib_v=0, ib_d=0, inflight=0, fa=RST_A, ib_pc=RST_A. The synchronous reset overrides flush and pop in the same cycle.
- Registers:
  - fa: next fetch address.
  - inflight: a ROM read was issued last cycle and must be captured.
  - cnt: 0..DEPTH.
  - head pointer and tail pointer: log2(DEPTH) bits, wrapping naturally.
- rom_a is combinational: flush ? flush_a : fa. The ROM always reads; the prefetcher decides only whether to capture.
- Issue rule:
  - issue = flush || (cnt + inflight < DEPTH). The pop in the same cycle is not credited.
  - On issue: inflight<=1, and fa<=rom_a+1 (wraps modulo 2^AW; the ROM wraps at 8K through its address slice).
  - Otherwise: inflight<=0 and fa holds.
- Capture: when inflight=1 and no flush this cycle, push rom_d at the tail.
- Pop: when ib_v && ib_rdy && !flush, advance the head and set ib_pc<=ib_pc+1.
- Push and pop in the same cycle leave cnt unchanged. By the issue rule, a push into a full FIFO cannot occur; the bench asserts this.
- Flush cycle:
  - cnt<=0 and pointers reset, so ib_v drops the next cycle.
  - A response in flight from the previous cycle is discarded.
  - ib_pc<=flush_a.
  - flush_a is issued this same cycle.
  - A simultaneous ib_rdy is ignored.
  - Back-to-back flushes are legal; only the last one is honoured.
- Latency:
  - Reset release: first cycle with rst=0 presents RST_A; ib_v=1 two cycles later.
  - Flush asserted in cycle f: ib_v=1 with ib_pc=flush_a in cycle f+2.
  - Throughput: 1 byte/cycle sustained when ib_rdy is held high.
- ib_v = (cnt != 0). ib_d reads the head entry combinationally from the register array.
- Stall with ib_rdy=0: the FIFO fills to DEPTH and issuing stops. Resuming with ib_rdy=1 gives no bubble, because entries are already buffered.

Decomposition:
- Shared package ej32_pkg holds:
  - the IU and U8 types
  - constant ROM_AW=13
  - the PF_DEPTH default
- One sub-module, ej32_bfifo: a parameterised byte FIFO with push, pop, clear, count and head data, and synchronous clear.
- The prefetch control (fa, inflight, issue rule, ib_pc) stays in ej32_prefetch.

Test Plan:
- Reset release: ROM[0..3]=8'h10,20,30,40, ib_rdy=1 -> ib_v rises 2 cycles after rst falls; ib_d/ib_pc sequence is 10/0, 20/1, 30/2, 40/3 on consecutive cycles.
- Backpressure: ib_rdy=0 for 10 cycles -> cnt saturates at 4, rom_a holds at 4, no FIFO overflow. On ib_rdy=1 -> 4 bytes, then byte 4, with no gap.
- Flush: flush=1, flush_a=32'h0100 while the FIFO holds 3 bytes and a read is in flight -> rom_a=0x100 in the same cycle; ib_v=0 the next cycle; ib_v=1 with ib_pc=0x100 and ib_d=ROM[0x100] two cycles after the flush; no stale bytes delivered.
- Flush coincident with ib_rdy=1 and back-to-back flushes to 0x200 then 0x300 -> the head pop is ignored and only 0x300 bytes appear.
- Wrap: flush_a=32'h1FFE -> ib_pc sequence 1FFE, 1FFF, 2000. The ROM returns the bytes at 0x1FFE, 0x1FFF, 0x0000.
- Mid-stream reset: rst=1 for one cycle during streaming with a flush asserted -> ib_v=0 and ib_pc=RST_A next cycle; restart latency is again 2 cycles.
